gng_stat: RTL and testbench

- Sink-side companion to the Gaussian noise generator: consumes its valid/data stream (s<16,11>) and drives its clock-enable.
- Over a window of 2^LOG2_N accepted samples, accumulates sum, sum of squares, minimum and maximum, then presents latched results with a done pulse.
- Used for on-chip self-check of the generator's mean and variance, and as the bench-side reader of its output interface.

---
 rtl/gng_stat.sv | 183 ++++++++++++++++++
 tb/tb_gng_stat.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gng_stat.sv
// gng_stat: sink-side statistics block for the Gaussian noise generator.
//
// Gates the generator with ce_out, accepts 2^LOG2_N valid samples (s<16,11>)
// and accumulates sum, sum of squares, minimum and maximum. At the end of the
// window it latches the results and pulses done for one cycle.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             single-cycle request to begin a window (ignored while busy)
//   ce_out            clock enable to the generator, high only in RUN
//   valid_in, data_in sample stream from the generator
//   busy              high in RUN and LATCH
//   done              one-cycle pulse, results updated on that cycle
//   sum_out           signed sum of samples (16+LOG2_N bits)
//   sumsq_out         unsigned sum of squares (31+LOG2_N bits)
//   mean_out          low 16 bits of sum_out >>> LOG2_N
//   min_out, max_out  signed extremes of the window
//
// Optional build macro GNG_STAT_HIST_EN adds a 16-bin histogram:
//   hist_sel          bin select
//   hist_cnt          registered read of the latched bin count (1-cycle latency)
//
// Handshake: a sample is consumed on every rising edge where the FSM is in
// RUN, valid_in is high and fewer than 2^LOG2_N samples have been taken.
// There is no back-pressure; ce_out only tells the generator when to run.
module gng_stat #(
  parameter int LOG2_N = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  ce_out,
  input  logic                  valid_in,
  input  logic [15:0]           data_in,
  output logic                  busy,
  output logic                  done,
  output logic [16+LOG2_N-1:0]  sum_out,
  output logic [31+LOG2_N-1:0]  sumsq_out,
  output logic [15:0]           mean_out,
  output logic [15:0]           min_out,
  output logic [15:0]           max_out
`ifdef GNG_STAT_HIST_EN
  ,
  input  logic [3:0]            hist_sel,
  output logic [LOG2_N:0]       hist_cnt
`endif
);

  localparam int N_W   = LOG2_N + 1;
  localparam int SUM_W = 16 + LOG2_N;
  localparam int SQ_W  = 31 + LOG2_N;
  localparam logic [N_W-1:0] N_SAMPLES = N_W'(1 << LOG2_N);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_LATCH = 2'd2
  } state_e;

  state_e                   state_q;
  logic [SUM_W-1:0]         sum_q, sum_d;
  logic [SQ_W-1:0]          sumsq_q, sumsq_d;
  logic [N_W-1:0]           cnt_q, cnt_d;
  logic signed [15:0]       min_q, min_d;
  logic signed [15:0]       max_q, max_d;
  logic signed [15:0]       sample;
  logic signed [31:0]       prod;
  logic                     accept;
  logic                     last;

  assign accept = (state_q == S_RUN) && valid_in && (cnt_q < N_SAMPLES);

  always_comb begin
    sample  = signed'(data_in);
    // Signed square is never negative and never exceeds 2^30, so plain
    // zero-extension into the accumulator is exact.
    prod    = sample * sample;
    sum_d   = sum_q + {{LOG2_N{sample[15]}}, sample};
    sumsq_d = sumsq_q + SQ_W'($unsigned(prod));
    cnt_d   = cnt_q + N_W'(1);
    // Strict compares keep the existing value on ties.
    min_d   = (sample < min_q) ? sample : min_q;
    max_d   = (sample > max_q) ? sample : max_q;
    last    = accept && (cnt_d == N_SAMPLES);
  end

  // Results are loaded on the edge that enters LATCH so that they are
  // visible on the same cycle as the done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ce_out    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum_q     <= '0;
      sumsq_q   <= '0;
      cnt_q     <= '0;
      min_q     <= 16'sh7FFF;
      max_q     <= -16'sh8000;
      sum_out   <= '0;
      sumsq_out <= '0;
      min_out   <= '0;
      max_out   <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            sum_q   <= '0;
            sumsq_q <= '0;
            cnt_q   <= '0;
            min_q   <= 16'sh7FFF;
            max_q   <= -16'sh8000;
            state_q <= S_RUN;
            ce_out  <= 1'b1;
            busy    <= 1'b1;
          end
        end
        S_RUN: begin
          if (accept) begin
            sum_q   <= sum_d;
            sumsq_q <= sumsq_d;
            cnt_q   <= cnt_d;
            min_q   <= min_d;
            max_q   <= max_d;
            if (last) begin
              state_q   <= S_LATCH;
              ce_out    <= 1'b0;
              done      <= 1'b1;
              sum_out   <= sum_d;
              sumsq_out <= sumsq_d;
              min_out   <= min_d;
              max_out   <= max_d;
            end
          end
        end
        S_LATCH: begin
          state_q <= S_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          ce_out  <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  assign mean_out = 16'($signed(sum_out) >>> LOG2_N);

`ifdef GNG_STAT_HIST_EN
  logic [N_W-1:0] hist_q    [16];
  logic [N_W-1:0] hist_snap [16];
  logic [3:0]     bin;

  // Flipping the sign bit orders bins from most negative to most positive.
  assign bin = data_in[15:12] ^ 4'b1000;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        hist_q[i]    <= '0;
        hist_snap[i] <= '0;
      end
      hist_cnt <= '0;
    end else begin
      if ((state_q == S_IDLE) && start) begin
        for (int i = 0; i < 16; i++) hist_q[i] <= '0;
      end else if (accept) begin
        hist_q[bin] <= hist_q[bin] + N_W'(1);
        if (last) begin
          for (int i = 0; i < 16; i++) begin
            hist_snap[i] <= hist_q[i] + ((4'(i) == bin) ? N_W'(1) : N_W'(0));
          end
        end
      end
      hist_cnt <= hist_snap[hist_sel];
    end
  end
`endif

endmodule

// File: tb/tb_gng_stat.sv
// Bench for gng_stat: a LOG2_N=4 instance for the main windows and a
// LOG2_N=1 instance for the extreme-value window. Expected results are
// computed from the driven sample lists and queued; a monitor pops and
// compares them on each done pulse.
module tb_gng_stat;

  localparam int L0  = 4;
  localparam int L1  = 1;
  localparam int EW0 = (16 + L0) + (31 + L0) + 48;
  localparam int EW1 = (16 + L1) + (31 + L1) + 48;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // dut0 (LOG2_N = 4)
  logic                 start, valid_in, ce_out, busy, done;
  logic [15:0]          data_in, mean_out, min_out, max_out;
  logic [16+L0-1:0]     sum_out;
  logic [31+L0-1:0]     sumsq_out;
`ifdef GNG_STAT_HIST_EN
  logic [3:0]           hist_sel;
  logic [L0:0]          hist_cnt;
`endif

  // dut1 (LOG2_N = 1)
  logic                 start1, valid1, ce1, busy1, done1;
  logic [15:0]          data1, mean1, min1, max1;
  logic [16+L1-1:0]     sum1;
  logic [31+L1-1:0]     sumsq1;

  gng_stat #(.LOG2_N(L0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .ce_out(ce_out),
    .valid_in(valid_in), .data_in(data_in), .busy(busy), .done(done),
    .sum_out(sum_out), .sumsq_out(sumsq_out), .mean_out(mean_out),
    .min_out(min_out), .max_out(max_out)
`ifdef GNG_STAT_HIST_EN
    , .hist_sel(hist_sel), .hist_cnt(hist_cnt)
`endif
  );

  gng_stat #(.LOG2_N(L1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .ce_out(ce1),
    .valid_in(valid1), .data_in(data1), .busy(busy1), .done(done1),
    .sum_out(sum1), .sumsq_out(sumsq1), .mean_out(mean1),
    .min_out(min1), .max_out(max1)
`ifdef GNG_STAT_HIST_EN
    , .hist_sel(4'd0), .hist_cnt()
`endif
  );

  // scoreboard
  logic [EW0-1:0] exp_q[$];
  logic [EW1-1:0] exp1_q[$];
  int n_cmp = 0;
  int n_mis = 0;
  int done_cnt = 0;
  int done1_cnt = 0;
  bit expect_done = 1'b0;
  bit expect_done1 = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      logic [EW0-1:0] e;
      done_cnt++;
      check("done_expected", expect_done, 1);
      check("exp_avail", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sum",   sum_out,   e[102:83]);
        check("sumsq", sumsq_out, e[82:48]);
        check("mean",  mean_out,  e[47:32]);
        check("min",   min_out,   e[31:16]);
        check("max",   max_out,   e[15:0]);
      end
    end
    if (done1) begin
      logic [EW1-1:0] e1;
      done1_cnt++;
      check("done1_expected", expect_done1, 1);
      check("exp1_avail", exp1_q.size() > 0, 1);
      if (exp1_q.size() > 0) begin
        e1 = exp1_q.pop_front();
        check("sum1",   sum1,   e1[96:80]);
        check("sumsq1", sumsq1, e1[79:48]);
        check("mean1",  mean1,  e1[47:32]);
        check("min1",   min1,   e1[31:16]);
        check("max1",   max1,   e1[15:0]);
      end
    end
  end

  // driver: one window on dut0
  task automatic run_window(input logic [15:0] s [16], input int gap_max,
                            input bit valid_on_start, input bit start_in_run,
                            input int extra_valids);
    int sum, mn, mx, v, d0;
    longint sq;
    logic [EW0-1:0] e;
    sum = 0; sq = 0; mn = 32767; mx = -32768;
    for (int i = 0; i < 16; i++) begin
      v = $signed(s[i]);
      sum += v;
      sq += longint'(v) * longint'(v);
      if (v < mn) mn = v;
      if (v > mx) mx = v;
    end
    e = {20'(sum), 35'(sq), 16'(sum >>> L0), 16'(mn), 16'(mx)};
    exp_q.push_back(e);
    d0 = done_cnt;

    @(posedge clk); #1;
    start = 1'b1; valid_in = valid_on_start; data_in = 16'h7FFF;
    @(posedge clk); #1;
    start = 1'b0; valid_in = 1'b0;
    check("ce_run", ce_out, 1);
    check("busy_run", busy, 1);
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(0, gap_max)) begin
        valid_in = 1'b0; data_in = 16'($urandom);
        @(posedge clk); #1;
      end
      valid_in = 1'b1; data_in = s[i];
      if (i == 15) expect_done = 1'b1;
      if (start_in_run && i == 7) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    check("done_latency", done, 1);
    check("ce_latch", ce_out, 0);
    check("busy_latch", busy, 1);
    valid_in = (extra_valids > 0); data_in = 16'($urandom);
    @(posedge clk); #1;
    expect_done = 1'b0;
    for (int i = 1; i < extra_valids; i++) begin
      data_in = 16'($urandom);
      @(posedge clk); #1;
    end
    valid_in = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("busy_idle", busy, 0);
    check("one_done", done_cnt - d0, 1);
    check("hold_sum", sum_out, e[102:83]);
    check("hold_min", min_out, e[31:16]);
  endtask

  logic [15:0] s [16];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    start = 0; valid_in = 0; data_in = 0;
    start1 = 0; valid1 = 0; data1 = 0;
`ifdef GNG_STAT_HIST_EN
    hist_sel = 0;
`endif
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_ce", ce_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum_out, 0);
    check("rst_sumsq", sumsq_out, 0);
    check("rst_mean", mean_out, 0);
    check("rst_min", min_out, 0);
    check("rst_max", max_out, 0);

    // constant 0x0800, back to back
    for (int i = 0; i < 16; i++) s[i] = 16'h0800;
    run_window(s, 0, 1'b0, 1'b0, 0);
    check("t1_sum_const", sum_out, 20'h08000);
    check("t1_sumsq_const", sumsq_out, 35'd1 << 26);
`ifdef GNG_STAT_HIST_EN
    for (int b = 0; b < 16; b++) begin
      hist_sel = 4'(b);
      @(posedge clk); #1;
      check("hist_bin", hist_cnt, (b == 8) ? 16 : 0);
    end
`endif

    // alternating +/-1.0 with random gaps
    for (int i = 0; i < 16; i++) s[i] = (i % 2 == 0) ? 16'h0800 : 16'hF800;
    run_window(s, 3, 1'b0, 1'b0, 0);
    check("t2_min_const", min_out, 16'hF800);

    // extremes on the LOG2_N=1 instance
    begin
      int sm, mn, mx, v;
      longint sq;
      logic [15:0] x [2];
      x[0] = 16'h8000; x[1] = 16'h7FFF;
      sm = 0; sq = 0; mn = 32767; mx = -32768;
      for (int i = 0; i < 2; i++) begin
        v = $signed(x[i]);
        sm += v; sq += longint'(v) * longint'(v);
        if (v < mn) mn = v;
        if (v > mx) mx = v;
      end
      exp1_q.push_back({17'(sm), 32'(sq), 16'(sm >>> L1), 16'(mn), 16'(mx)});
      @(posedge clk); #1; start1 = 1'b1;
      @(posedge clk); #1; start1 = 1'b0; valid1 = 1'b1; data1 = x[0];
      @(posedge clk); #1; data1 = x[1]; expect_done1 = 1'b1;
      @(posedge clk); #1; valid1 = 1'b0;
      check("t3_done_latency", done1, 1);
      @(posedge clk); #1; expect_done1 = 1'b0;
      check("t3_sum_const", sum1, 17'h1FFFF);
      check("t3_sumsq_const", sumsq1, 32'h4000_0000 + 32'h3FFF_0001);
      check("t3_one_done", done1_cnt, 1);
    end

    // random samples, start pulsed mid-window, extra valids after the window
    for (int i = 0; i < 16; i++) s[i] = 16'($urandom);
    run_window(s, 2, 1'b0, 1'b1, 5);

    // reset mid-window, then a fresh window (start coincides with a valid)
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      valid_in = 1'b1; data_in = 16'h1234;
      @(posedge clk); #1;
    end
    valid_in = 1'b0; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_ce", ce_out, 0);
    check("midrst_sum", sum_out, 0);
    check("midrst_max", max_out, 0);
    repeat (2) @(posedge clk); #1;
    for (int i = 0; i < 16; i++) s[i] = 16'h0100;
    run_window(s, 1, 1'b1, 1'b0, 0);
    check("t5_sum_const", sum_out, 20'h01000);

    check("exp_drained", exp_q.size() + exp1_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
